wb_data_ram: RTL
================

Name: wb_data_ram

Overview:
- Wishbone classic slave (responder) holding the core's data memory.
- Serves single-beat byte, halfword and word reads/writes issued by the load/store master.
- Configurable wait states.
- Terminates illegal accesses with err instead of ack.
- Sits on the data bus between the load/store unit and the memory array; one cycle bubble between transactions.

Parameters:
- DEPTH, 1024, number of 32-bit words in the array (power of two).
- BASE_ADDR, 32'h0000_0000, byte address of word 0 (word aligned).
- WAIT_STATES, 0, extra cycles inserted before the response (0..15).

Ports:
- clk_i  in  1  system clock, all logic on rising edge
- rst_i  in  1  synchronous active-high reset
- wbs_cyc_i  in  1  bus cycle active
- wbs_stb_i  in  1  strobe, request valid
- wbs_we_i  in  1  1 = write, 0 = read
- wbs_adr_i  in  32  byte address; bits [1:0] ignored (lanes come from sel)
- wbs_dat_i  in  32  write data, byte lanes aligned to sel
- wbs_sel_i  in  4  byte-lane select
- wbs_dat_o  out  32  read data, full word, valid while ack high
- wbs_ack_o  out  1  normal termination, one-cycle pulse
- wbs_err_o  out  1  error termination, one-cycle pulse

Behaviour:
- Clock and reset: one clock, clk_i. Reset is synchronous, active-high, on rst_i.
- Reset values: state=IDLE, wbs_ack_o=0, wbs_err_o=0, wbs_dat_o=0, wait counter=0. Array contents are not reset.
- State machine: IDLE, WAIT, RESP. All outputs are registered.
- IDLE:
  - Exits only when cyc_i & stb_i are sampled high at an edge.
  - On that edge, latch we, adr, dat, sel and compute bad.
  - Next state is WAIT with cnt=WAIT_STATES-1 if WAIT_STATES>0, else RESP.
- bad is set when any of:
  - (adr[31:2]-BASE_ADDR[31:2]) >= DEPTH (unsigned, 30-bit arithmetic, wrap counts as out of range);
  - sel is not one of 0001, 0010, 0100, 1000, 0011, 1100, 1111 (includes 0000).
- WAIT:
  - If cyc_i=0 at an edge, abort to IDLE: no write, no ack/err.
  - Otherwise decrement cnt; when cnt=0 go to RESP.
- Entering RESP (the edge that makes ack/err high):
  - If !bad & we: write the selected byte lanes of the latched data into word index=adr[31:2]-BASE_ADDR[31:2]. Unselected lanes are unchanged.
  - If !bad & !we: dat_o <= word at that index (all 4 bytes). The master performs lane extraction and sign extension.
  - If bad: err=1, ack=0, no array change, dat_o <= 0.
- RESP:
  - ack_o (or err_o) is high for exactly this one cycle.
  - Next state is IDLE unconditionally, regardless of cyc/stb.
  - The master must drop stb on the edge where it sees ack/err.
  - dat_o holds its value until the next read response.
- Latency: request sampled at edge k; ack/err high during cycle k+1+WAIT_STATES.
- Simultaneous events:
  - rst_i wins over everything. Reset during WAIT aborts with no write.
  - Reset during RESP clears ack/err at that edge; a write that entered RESP is already committed.
- ack_o and err_o are never high together. Neither is ever high outside RESP.
- Address range is checked on the latched address only; changes to adr_i after sampling are ignored.
- A write followed by a read of the same word returns the new data: no bypass needed, since the write commits before the read is sampled.

Test Plan:
- WAIT_STATES=0, write adr=0x10 sel=1111 dat=0xDEADBEEF, then read adr=0x10 -> each ack high exactly 1 cycle, 1 cycle after stb sampled; read dat_o=0xDEADBEEF, err never asserted.
- Byte write adr=0x11 sel=0010 dat=0x0000AA00 over word 0xDEADBEEF, then read -> dat_o=0xDEADAAEF; halfword write sel=1100 dat=0x12340000 then read -> 0x1234AAEF.
- Read adr=BASE_ADDR+4*DEPTH, then sel=0101 write to 0x20 -> err pulses 1 cycle, ack stays 0; subsequent read of 0x20 returns its prior value unchanged.
- WAIT_STATES=3, read adr=0x10 -> ack rises in cycle k+4; master deasserts cyc during WAIT on a write instead -> no ack/err, memory unchanged, next request served normally.
- Back-to-back: stb dropped for one cycle after each ack, three writes then three reads to 0x0/0x4/0x8 -> six acks, each 1 cycle, reads return written values in order.
- Assert rst_i during WAIT of a write (WAIT_STATES=2) -> ack/err/dat_o all 0 next cycle, state IDLE, target word unchanged.

Source files
------------

// File: rtl/wb_data_ram.sv
// rtl/wb_data_ram.sv - Wishbone classic data RAM slave with wait states and err termination
module wb_data_ram #(
    parameter int          DEPTH       = 1024,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
    parameter int          WAIT_STATES = 0
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        wbs_cyc_i,
    input  logic        wbs_stb_i,
    input  logic        wbs_we_i,
    input  logic [31:0] wbs_adr_i,
    input  logic [31:0] wbs_dat_i,
    input  logic [3:0]  wbs_sel_i,
    output logic [31:0] wbs_dat_o,
    output logic        wbs_ack_o,
    output logic        wbs_err_o
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

    state_t         state;
    logic           we_q;
    logic           bad_q;
    logic [AW-1:0]  idx_q;
    logic [31:0]    dat_q;
    logic [3:0]     sel_q;
    logic [3:0]     cnt;
    logic [31:0]    mem [DEPTH];

    function automatic logic sel_ok(input logic [3:0] s);
        case (s)
            4'b0001, 4'b0010, 4'b0100, 4'b1000,
            4'b0011, 4'b1100, 4'b1111: return 1'b1;
            default:                   return 1'b0;
        endcase
    endfunction

    // Offset is 30-bit modular, so addresses below BASE_ADDR wrap high and fail the range test.
    logic [29:0] req_off;
    logic        req_bad;
    assign req_off = wbs_adr_i[31:2] - BASE_ADDR[31:2];
    assign req_bad = (req_off >= 30'(DEPTH)) || !sel_ok(wbs_sel_i);

    logic unused_bits;
    assign unused_bits = &{1'b0, wbs_adr_i[1:0], req_off};

    // The response action happens on the edge that enters RESP; with no wait states that
    // edge is the sampling edge itself, so the request fields come straight off the bus.
    logic           go_resp;
    logic           c_we;
    logic           c_bad;
    logic [AW-1:0]  c_idx;
    logic [31:0]    c_dat;
    logic [3:0]     c_sel;

    always_comb begin
        go_resp = 1'b0;
        c_we    = we_q;
        c_bad   = bad_q;
        c_idx   = idx_q;
        c_dat   = dat_q;
        c_sel   = sel_q;
        case (state)
            S_IDLE: begin
                c_we  = wbs_we_i;
                c_bad = req_bad;
                c_idx = req_off[AW-1:0];
                c_dat = wbs_dat_i;
                c_sel = wbs_sel_i;
                if (WAIT_STATES == 0 && wbs_cyc_i && wbs_stb_i)
                    go_resp = 1'b1;
            end
            S_WAIT: begin
                if (wbs_cyc_i && cnt == 4'd0)
                    go_resp = 1'b1;
            end
            default: go_resp = 1'b0;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i && go_resp && !c_bad && c_we) begin
            for (int b = 0; b < 4; b++) begin
                if (c_sel[b])
                    mem[c_idx][8*b +: 8] <= c_dat[8*b +: 8];
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state     <= S_IDLE;
            wbs_ack_o <= 1'b0;
            wbs_err_o <= 1'b0;
            wbs_dat_o <= 32'h0;
            cnt       <= 4'd0;
            we_q      <= 1'b0;
            bad_q     <= 1'b0;
            idx_q     <= '0;
            dat_q     <= 32'h0;
            sel_q     <= 4'h0;
        end else begin
            wbs_ack_o <= 1'b0;
            wbs_err_o <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (wbs_cyc_i && wbs_stb_i) begin
                        we_q  <= wbs_we_i;
                        bad_q <= req_bad;
                        idx_q <= req_off[AW-1:0];
                        dat_q <= wbs_dat_i;
                        sel_q <= wbs_sel_i;
                        if (WAIT_STATES > 0) begin
                            cnt   <= 4'(WAIT_STATES - 1);
                            state <= S_WAIT;
                        end else begin
                            state <= S_RESP;
                        end
                    end
                end
                S_WAIT: begin
                    if (!wbs_cyc_i)
                        state <= S_IDLE;
                    else if (cnt == 4'd0)
                        state <= S_RESP;
                    else
                        cnt <= cnt - 4'd1;
                end
                default: state <= S_IDLE;
            endcase
            if (go_resp) begin
                if (c_bad) begin
                    wbs_err_o <= 1'b1;
                    wbs_dat_o <= 32'h0;
                end else begin
                    wbs_ack_o <= 1'b1;
                    if (!c_we)
                        wbs_dat_o <= mem[c_idx];
                end
            end
        end
    end
endmodule
